tmod_sample_ctrl: RTL and testbench
===================================

TMOD_SAMPLE_CTRL -- requirements
Module: tmod_sample_ctrl

Interface
REQ-001 Parameter W, default 8: temperature sample width in bits.
REQ-002 Parameter DEPTH, default 8: sample ring depth; SHALL be a power of two >= 2; LD = log2(DEPTH).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tick  in  1  base time-tick pulse, one clk wide.
REQ-006 temp  in  W  current sensor temperature, unsigned.
REQ-007 en  in  1  sampling enable, level.
REQ-008 clear  in  1  flush ring pointers and statistics, one-cycle pulse.
REQ-009 cfg_we  in  1  load cfg_frq into frq register.
REQ-010 cfg_frq  in  8  ticks-per-sample minus one.
REQ-011 buf_re  out  1  ring buffer read strobe.
REQ-012 buf_raddr  out  LD  ring buffer read address.
REQ-013 buf_rdata  in  W  ring buffer read data, valid the cycle after buf_re.
REQ-014 buf_we / buf_waddr / buf_wdata  out  1 / LD / W  ring buffer write port.
REQ-015 count  out  LD+1  samples held in ring, 0..DEPTH.
REQ-016 max_t / min_t / avg_t  out  W / W / W  statistics.
REQ-017 stat_valid / avg_valid / busy / overrun  out  1 each  status flags.

Function
REQ-018 States SHALL be IDLE, COUNT, CAPTURE, READ_OLD, WRITE, UPDATE.
REQ-019 IDLE: en=1 -> COUNT with tick_cnt=0; otherwise stay.
REQ-020 COUNT: en=0 -> IDLE; on tick: tick_cnt==frq -> CAPTURE and tick_cnt=0, else tick_cnt+1.
REQ-021 frq=0 SHALL sample on every tick; frq=N SHALL sample on every (N+1)th tick.
REQ-022 CAPTURE: sample_r <= temp at end of cycle -> READ_OLD.
REQ-023 READ_OLD: buf_re=1, buf_raddr=wptr -> WRITE.
REQ-024 WRITE: old_r <= buf_rdata; buf_we=1, buf_waddr=wptr, buf_wdata=sample_r; wptr increments, DEPTH-1 wraps to 0; count increments, saturating at DEPTH -> UPDATE.
REQ-025 UPDATE: sum <= sum + sample_r - (count was DEPTH before WRITE ? old_r : 0); max_t/min_t updated with sample_r -> COUNT if en else IDLE.
REQ-026 sum SHALL be W+LD bits, never overflows; avg_t = sum >> LD when avg_valid, else 0.
REQ-027 max_t/min_t SHALL be extrema over all samples since last reset/clear, not just ring contents.
REQ-028 Latency: qualifying tick in cycle T -> buf_we in T+3 -> statistics visible in T+5.
REQ-029 busy=1 in CAPTURE, READ_OLD, WRITE, UPDATE; stat_valid = (count!=0); avg_valid = (count==DEPTH).
REQ-030 tick while busy SHALL be ignored (tick_cnt unchanged) and SHALL pulse overrun for that cycle.
REQ-031 en deasserted while busy: current sample completes, then IDLE.
REQ-032 cfg_we in any state: frq <= cfg_frq, tick_cnt <= 0; same-cycle tick in COUNT SHALL NOT sample.
REQ-033 clear in any state: wptr=0, count=0, sum=0, max_t=0, min_t=all ones, tick_cnt=0; next state COUNT if en else IDLE; buf_we forced 0 that cycle; in-flight sample discarded.
REQ-034 Priority: reset > clear > cfg_we > tick.

Reset
REQ-035 Reset SHALL force state IDLE, frq=0, tick_cnt=0, wptr=0, count=0, sum=0, sample_r=0, old_r=0.
REQ-036 Reset outputs: buf_re=0, buf_we=0, buf_raddr=0, buf_waddr=0, buf_wdata=0, max_t=0, min_t=all ones, avg_t=0, stat_valid=0, avg_valid=0, busy=0, overrun=0.
REQ-037 Reset asserted mid-sample SHALL abort it with no buf_we the following cycle.

Verification
REQ-038 frq=2, en=1, temp=40, 3 ticks -> one buf_we at addr 0 data 40 three cycles after third tick; count=1, max_t=min_t=40, avg_valid=0.
REQ-039 frq=0, DEPTH=8, temps 10,20,...,80 one per tick spaced 6 cycles -> count=8, avg_valid=1, avg_t=45, wptr wraps to 0.
REQ-040 Ring full, ninth sample 90 -> buf_raddr=0 read returns 10, sum 360->440, avg_t=55, max_t=90, min_t=10.
REQ-041 tick in CAPTURE and UPDATE -> overrun pulses twice, no extra buf_we, tick_cnt unchanged.
REQ-042 clear during WRITE -> buf_we=0 that cycle, count=0, min_t=255, max_t=0, stat_valid=0.
REQ-043 cfg_we with tick same cycle in COUNT at tick_cnt==frq -> no sample, tick_cnt=0, frq = new value.

Source files
------------

// File: rtl/tmod_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tmod_sample_ctrl
//
// Periodic temperature sampler. Every (frq+1) qualifying ticks it captures
// temp_i, pushes it into an external DEPTH-entry ring buffer, and maintains
// running statistics: sample count, max, min (since reset/clear) and the mean
// of the ring contents. The mean uses a running sum, so the entry that is
// about to be overwritten is read back first and subtracted once the ring is
// full.
//
// Handshake / timing: there is no valid/ready pair here. A tick qualifies only
// in COUNT; a qualifying tick in cycle T gives buf_re in T+2, buf_we in T+3
// and updated statistics from T+5. buf_rdata_i must be valid the cycle after
// buf_re_o (registered RAM read). Ticks arriving while busy are dropped and
// flagged on overrun_o for that cycle.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   tick_i                  base time tick, one clk wide
//   temp_i[W]               sensor temperature, unsigned
//   en_i                    sampling enable (level)
//   clear_i                 flush ring pointers and statistics (pulse)
//   cfg_we_i, cfg_frq_i[8]  load ticks-per-sample minus one
//   buf_re_o, buf_raddr_o   ring read port, buf_rdata_i[W] returns next cycle
//   buf_we_o, buf_waddr_o, buf_wdata_o   ring write port
//   count_o[LD+1]           samples held in ring (0..DEPTH)
//   max_t_o, min_t_o, avg_t_o            statistics
//   stat_valid_o, avg_valid_o, busy_o, overrun_o   status flags
//   state_o[3]              current FSM state (debug)
// ---------------------------------------------------------------------------
module tmod_sample_ctrl #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int LD   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          tick_i,
  input  logic [W-1:0]  temp_i,
  input  logic          en_i,
  input  logic          clear_i,
  input  logic          cfg_we_i,
  input  logic [7:0]    cfg_frq_i,
  output logic          buf_re_o,
  output logic [LD-1:0] buf_raddr_o,
  input  logic [W-1:0]  buf_rdata_i,
  output logic          buf_we_o,
  output logic [LD-1:0] buf_waddr_o,
  output logic [W-1:0]  buf_wdata_o,
  output logic [LD:0]   count_o,
  output logic [W-1:0]  max_t_o,
  output logic [W-1:0]  min_t_o,
  output logic [W-1:0]  avg_t_o,
  output logic          stat_valid_o,
  output logic          avg_valid_o,
  output logic          busy_o,
  output logic          overrun_o,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COUNT    = 3'd1,
    S_CAPTURE  = 3'd2,
    S_READ_OLD = 3'd3,
    S_WRITE    = 3'd4,
    S_UPDATE   = 3'd5
  } state_t;

  localparam logic [LD:0] CNT_FULL = (LD+1)'(DEPTH);

  state_t          state_q;
  logic [7:0]      frq_q;
  logic [7:0]      tick_cnt_q;
  logic [LD-1:0]   wptr_q;
  logic [LD:0]     count_q;
  logic [W+LD-1:0] sum_q;
  logic [W-1:0]    sample_q;
  logic [W-1:0]    old_q;
  logic            full_q;     // ring was full before this sample's WRITE
  logic [W-1:0]    max_q;
  logic [W-1:0]    min_q;
  logic            buf_re_q;
  logic [LD-1:0]   buf_raddr_q;
  logic            buf_we_q;
  logic [LD-1:0]   buf_waddr_q;
  logic [W-1:0]    buf_wdata_q;

  logic            busy;
  logic [W+LD-1:0] sum_d;

  assign busy = (state_q == S_CAPTURE) || (state_q == S_READ_OLD) ||
                (state_q == S_WRITE)   || (state_q == S_UPDATE);

  // Add the new sample and retire the overwritten one in a single step. The
  // intermediate sum may wrap, but the final result always fits W+LD bits.
  assign sum_d = sum_q + {{LD{1'b0}}, sample_q}
               - (full_q ? {{LD{1'b0}}, old_q} : {(W+LD){1'b0}});

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      frq_q       <= 8'd0;
      tick_cnt_q  <= 8'd0;
      wptr_q      <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      sample_q    <= '0;
      old_q       <= '0;
      full_q      <= 1'b0;
      max_q       <= '0;
      min_q       <= '1;
      buf_re_q    <= 1'b0;
      buf_raddr_q <= '0;
      buf_we_q    <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
    end else begin
      buf_re_q <= 1'b0;
      buf_we_q <= 1'b0;
      if (cfg_we_i) begin
        frq_q <= cfg_frq_i;
      end
      if (clear_i) begin
        // Any in-flight sample is dropped; the pulses above are already 0.
        wptr_q     <= '0;
        count_q    <= '0;
        sum_q      <= '0;
        max_q      <= '0;
        min_q      <= '1;
        full_q     <= 1'b0;
        tick_cnt_q <= 8'd0;
        state_q    <= en_i ? S_COUNT : S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (en_i) begin
              state_q    <= S_COUNT;
              tick_cnt_q <= 8'd0;
            end
          end
          S_COUNT: begin
            if (!en_i) begin
              state_q <= S_IDLE;
            end else if (tick_i && !cfg_we_i) begin
              if (tick_cnt_q == frq_q) begin
                state_q    <= S_CAPTURE;
                tick_cnt_q <= 8'd0;
              end else begin
                tick_cnt_q <= tick_cnt_q + 8'd1;
              end
            end
          end
          S_CAPTURE: begin
            sample_q    <= temp_i;
            buf_re_q    <= 1'b1;
            buf_raddr_q <= wptr_q;
            state_q     <= S_READ_OLD;
          end
          S_READ_OLD: begin
            buf_we_q    <= 1'b1;
            buf_waddr_q <= wptr_q;
            buf_wdata_q <= sample_q;
            state_q     <= S_WRITE;
          end
          S_WRITE: begin
            old_q  <= buf_rdata_i;
            full_q <= (count_q == CNT_FULL);
            wptr_q <= wptr_q + LD'(1);
            if (count_q != CNT_FULL) begin
              count_q <= count_q + (LD+1)'(1);
            end
            state_q <= S_UPDATE;
          end
          S_UPDATE: begin
            sum_q <= sum_d;
            if (sample_q > max_q) max_q <= sample_q;
            if (sample_q < min_q) min_q <= sample_q;
            state_q <= en_i ? S_COUNT : S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
        // A configuration write restarts the tick divider in every state.
        if (cfg_we_i) begin
          tick_cnt_q <= 8'd0;
        end
      end
    end
  end

  assign buf_re_o     = buf_re_q;
  assign buf_raddr_o  = buf_raddr_q;
  // clear (and reset) suppress a write already scheduled for this cycle.
  assign buf_we_o     = buf_we_q & ~clear_i & ~reset_i;
  assign buf_waddr_o  = buf_waddr_q;
  assign buf_wdata_o  = buf_wdata_q;
  assign count_o      = count_q;
  assign max_t_o      = max_q;
  assign min_t_o      = min_q;
  assign stat_valid_o = (count_q != '0);
  assign avg_valid_o  = (count_q == CNT_FULL);
  assign avg_t_o      = avg_valid_o ? sum_q[W+LD-1:LD] : '0;
  assign busy_o       = busy;
  assign overrun_o    = tick_i & busy & ~clear_i & ~reset_i;
  assign state_o      = state_q;

endmodule

// File: tb/tb_tmod_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tmod_sample_ctrl
//
// Directed bench for tmod_sample_ctrl (W=8, DEPTH=8). A small registered RAM
// model serves the ring buffer port. Inputs change one time unit after the
// rising edge (or at the falling edge); outputs are observed on the falling
// edge. Each scenario task compares observed values with hand-computed
// expectations inline.
// ---------------------------------------------------------------------------
module tb_tmod_sample_ctrl;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int LD    = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COUNT    = 3'd1;
  localparam logic [2:0] ST_READ_OLD = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_UPDATE   = 3'd5;

  logic          clk;
  logic          reset_i;
  logic          tick_i;
  logic [W-1:0]  temp_i;
  logic          en_i;
  logic          clear_i;
  logic          cfg_we_i;
  logic [7:0]    cfg_frq_i;
  logic          buf_re_o;
  logic [LD-1:0] buf_raddr_o;
  logic [W-1:0]  buf_rdata_i;
  logic          buf_we_o;
  logic [LD-1:0] buf_waddr_o;
  logic [W-1:0]  buf_wdata_o;
  logic [LD:0]   count_o;
  logic [W-1:0]  max_t_o;
  logic [W-1:0]  min_t_o;
  logic [W-1:0]  avg_t_o;
  logic          stat_valid_o;
  logic          avg_valid_o;
  logic          busy_o;
  logic          overrun_o;
  logic [2:0]    state_o;

  int n_chk;
  int n_fail;
  int we_cnt;
  int ov_cnt;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_q[$];

  tmod_sample_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .tick_i       (tick_i),
    .temp_i       (temp_i),
    .en_i         (en_i),
    .clear_i      (clear_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_frq_i    (cfg_frq_i),
    .buf_re_o     (buf_re_o),
    .buf_raddr_o  (buf_raddr_o),
    .buf_rdata_i  (buf_rdata_i),
    .buf_we_o     (buf_we_o),
    .buf_waddr_o  (buf_waddr_o),
    .buf_wdata_o  (buf_wdata_o),
    .count_o      (count_o),
    .max_t_o      (max_t_o),
    .min_t_o      (min_t_o),
    .avg_t_o      (avg_t_o),
    .stat_valid_o (stat_valid_o),
    .avg_valid_o  (avg_valid_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o),
    .state_o      (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- ring RAM model and monitor ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    buf_rdata_i = '0;
  end

  always @(posedge clk) begin
    if (buf_we_o) mem[buf_waddr_o] <= buf_wdata_o;
    if (buf_re_o) buf_rdata_i <= mem[buf_raddr_o];
  end

  always @(negedge clk) begin
    if (buf_we_o) begin
      we_cnt++;
      wr_q.push_back(buf_wdata_o);
    end
    if (overrun_o) ov_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Tick is sampled at the end of the current cycle; returns one time unit
  // into the following cycle.
  task automatic do_tick();
    tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step(2);
    reset_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_i = 1'b1; tick_i = 1'b1; en_i = 1'b1;
    step(1);
    @(negedge clk);
    n_chk++; if (buf_re_o !== 1'b0) begin n_fail++; $display("FAIL rst_buf_re: got %0d want 0", buf_re_o); end
    n_chk++; if (buf_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_buf_we: got %0d want 0", buf_we_o); end
    n_chk++; if (buf_raddr_o !== 3'd0) begin n_fail++; $display("FAIL rst_raddr: got %0d want 0", buf_raddr_o); end
    n_chk++; if (buf_waddr_o !== 3'd0) begin n_fail++; $display("FAIL rst_waddr: got %0d want 0", buf_waddr_o); end
    n_chk++; if (buf_wdata_o !== 8'd0) begin n_fail++; $display("FAIL rst_wdata: got %0d want 0", buf_wdata_o); end
    n_chk++; if (max_t_o !== 8'd0) begin n_fail++; $display("FAIL rst_max: got %0d want 0", max_t_o); end
    n_chk++; if (min_t_o !== 8'hFF) begin n_fail++; $display("FAIL rst_min: got %0d want 255", min_t_o); end
    n_chk++; if (avg_t_o !== 8'd0) begin n_fail++; $display("FAIL rst_avg: got %0d want 0", avg_t_o); end
    n_chk++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count_o); end
    n_chk++; if ({stat_valid_o, avg_valid_o, busy_o, overrun_o} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {stat_valid_o, avg_valid_o, busy_o, overrun_o}); end
    n_chk++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state_o, ST_IDLE); end
    step(1);
    reset_i = 1'b0; tick_i = 1'b0; en_i = 1'b0;
  endtask

  task automatic test_single_sample();
    en_i = 1'b1; cfg_we_i = 1'b1; cfg_frq_i = 8'd2; temp_i = 8'd40;
    step(1);
    cfg_we_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_tick();
      @(negedge clk);
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_early_tick%0d_busy: got %0d want 0", i, busy_o); end
    end
    do_tick();                     // third tick, cycle T
    @(negedge clk);                // T+1
    n_chk++; if (buf_we_o !== 1'b0) begin n_fail++; $display("FAIL single_we_t1: got %0d want 0", buf_we_o); end
    step(1); @(negedge clk);       // T+2
    n_chk++; if ({buf_re_o, buf_raddr_o} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL single_read: got re=%0d addr=%0d want re=1 addr=0", buf_re_o, buf_raddr_o); end
    n_chk++; if (buf_we_o !== 1'b0) begin n_fail++; $display("FAIL single_we_t2: got %0d want 0", buf_we_o); end
    step(1); @(negedge clk);       // T+3
    n_chk++; if ({buf_we_o, buf_waddr_o, buf_wdata_o} !== {1'b1, 3'd0, 8'd40}) begin n_fail++; $display("FAIL single_write: got we=%0d addr=%0d data=%0d want we=1 addr=0 data=40", buf_we_o, buf_waddr_o, buf_wdata_o); end
    step(2); @(negedge clk);       // T+5
    n_chk++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count_o); end
    n_chk++; if ({max_t_o, min_t_o} !== {8'd40, 8'd40}) begin n_fail++; $display("FAIL single_maxmin: got max=%0d min=%0d want 40/40", max_t_o, min_t_o); end
    n_chk++; if ({stat_valid_o, avg_valid_o, avg_t_o} !== {1'b1, 1'b0, 8'd0}) begin n_fail++; $display("FAIL single_valid: got sv=%0d av=%0d avg=%0d want 1/0/0", stat_valid_o, avg_valid_o, avg_t_o); end
    n_chk++; if (state_o !== ST_COUNT) begin n_fail++; $display("FAIL single_state: got %0d want %0d", state_o, ST_COUNT); end
  endtask

  task automatic test_fill_ring();
    do_reset();
    en_i = 1'b1; cfg_we_i = 1'b1; cfg_frq_i = 8'd0;
    step(1);
    cfg_we_i = 1'b0;
    exp_q.delete();
    wr_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      temp_i = 8'(10 * (k + 1));
      exp_q.push_back(temp_i);
      do_tick();
      step(2); @(negedge clk);     // T+3
      n_chk++; if ({buf_we_o, buf_waddr_o, buf_wdata_o} !== {1'b1, 3'(k), temp_i}) begin n_fail++; $display("FAIL fill_write%0d: got we=%0d addr=%0d data=%0d want 1/%0d/%0d", k, buf_we_o, buf_waddr_o, buf_wdata_o, k, temp_i); end
      step(3);                     // next tick six cycles later
    end
    @(negedge clk);
    n_chk++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fill_nwrites: got %0d want %0d", wr_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && wr_q.size() != 0) begin
      logic [W-1:0] e;
      logic [W-1:0] o;
      e = exp_q.pop_front();
      o = wr_q.pop_front();
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL fill_sb: got %0d want %0d", o, e); end
    end
    n_chk++; if ({count_o, avg_valid_o, avg_t_o} !== {4'd8, 1'b1, 8'd45}) begin n_fail++; $display("FAIL fill_stats: got cnt=%0d av=%0d avg=%0d want 8/1/45", count_o, avg_valid_o, avg_t_o); end
    n_chk++; if ({max_t_o, min_t_o} !== {8'd80, 8'd10}) begin n_fail++; $display("FAIL fill_maxmin: got max=%0d min=%0d want 80/10", max_t_o, min_t_o); end
  endtask

  task automatic test_overwrite();
    temp_i = 8'd90;
    do_tick();
    step(1); @(negedge clk);       // T+2: wptr wrapped back to 0
    n_chk++; if ({buf_re_o, buf_raddr_o} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL ovw_read: got re=%0d addr=%0d want 1/0", buf_re_o, buf_raddr_o); end
    step(1); @(negedge clk);       // T+3
    n_chk++; if (buf_rdata_i !== 8'd10) begin n_fail++; $display("FAIL ovw_old: got %0d want 10", buf_rdata_i); end
    n_chk++; if ({buf_we_o, buf_waddr_o, buf_wdata_o} !== {1'b1, 3'd0, 8'd90}) begin n_fail++; $display("FAIL ovw_write: got we=%0d addr=%0d data=%0d want 1/0/90", buf_we_o, buf_waddr_o, buf_wdata_o); end
    step(2); @(negedge clk);       // T+5
    n_chk++; if ({count_o, avg_t_o} !== {4'd8, 8'd55}) begin n_fail++; $display("FAIL ovw_avg: got cnt=%0d avg=%0d want 8/55", count_o, avg_t_o); end
    n_chk++; if ({max_t_o, min_t_o} !== {8'd90, 8'd10}) begin n_fail++; $display("FAIL ovw_maxmin: got max=%0d min=%0d want 90/10", max_t_o, min_t_o); end
  endtask

  task automatic test_overrun();
    int we0;
    int ov0;
    cfg_we_i = 1'b1; cfg_frq_i = 8'd1;
    step(1);
    cfg_we_i = 1'b0;
    temp_i = 8'd50;
    we0 = we_cnt; ov0 = ov_cnt;
    do_tick();
    do_tick();                     // qualifying tick, T
    tick_i = 1'b1;                 // T+1 CAPTURE
    @(negedge clk);
    n_chk++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_capture: got %0d want 1", overrun_o); end
    step(1);
    tick_i = 1'b0;
    step(2);                       // T+4 UPDATE
    tick_i = 1'b1;
    @(negedge clk);
    n_chk++; if ({state_o, overrun_o} !== {ST_UPDATE, 1'b1}) begin n_fail++; $display("FAIL ovr_update: got st=%0d ovr=%0d want %0d/1", state_o, overrun_o, ST_UPDATE); end
    step(1);
    tick_i = 1'b0;
    n_chk++; if ((ov_cnt - ov0) != 2) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 2", ov_cnt - ov0); end
    n_chk++; if ((we_cnt - we0) != 1) begin n_fail++; $display("FAIL ovr_writes: got %0d want 1", we_cnt - we0); end
    // divider must not have advanced: one more tick is needed before sampling
    do_tick();
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ovr_cnt_hold: got busy=%0d want 0", busy_o); end
    do_tick();
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ovr_cnt_sample: got busy=%0d want 1", busy_o); end
    step(4);
    n_chk++; if ((we_cnt - we0) != 2) begin n_fail++; $display("FAIL ovr_writes2: got %0d want 2", we_cnt - we0); end
    @(negedge clk);
    n_chk++; if (avg_t_o !== 8'd61) begin n_fail++; $display("FAIL ovr_avg: got %0d want 61", avg_t_o); end
  endtask

  task automatic test_clear();
    temp_i = 8'd70;
    do_tick();
    do_tick();                     // T
    step(2);                       // T+3 WRITE
    clear_i = 1'b1;
    @(negedge clk);
    n_chk++; if ({state_o, buf_we_o} !== {ST_WRITE, 1'b0}) begin n_fail++; $display("FAIL clr_we: got st=%0d we=%0d want %0d/0", state_o, buf_we_o, ST_WRITE); end
    step(1);
    clear_i = 1'b0;
    @(negedge clk);
    n_chk++; if ({count_o, stat_valid_o, avg_valid_o, avg_t_o} !== {4'd0, 1'b0, 1'b0, 8'd0}) begin n_fail++; $display("FAIL clr_count: got cnt=%0d sv=%0d av=%0d avg=%0d want 0/0/0/0", count_o, stat_valid_o, avg_valid_o, avg_t_o); end
    n_chk++; if ({max_t_o, min_t_o} !== {8'd0, 8'd255}) begin n_fail++; $display("FAIL clr_maxmin: got max=%0d min=%0d want 0/255", max_t_o, min_t_o); end
    n_chk++; if ({state_o, busy_o} !== {ST_COUNT, 1'b0}) begin n_fail++; $display("FAIL clr_state: got st=%0d busy=%0d want %0d/0", state_o, busy_o, ST_COUNT); end
    n_chk++; if (mem[3] !== 8'd40) begin n_fail++; $display("FAIL clr_ram: got %0d want 40", mem[3]); end
  endtask

  task automatic test_cfg_tick();
    temp_i = 8'd60;
    do_tick();                     // divider now equals frq (1)
    tick_i = 1'b1; cfg_we_i = 1'b1; cfg_frq_i = 8'd3;
    step(1);
    tick_i = 1'b0; cfg_we_i = 1'b0;
    @(negedge clk);
    n_chk++; if ({state_o, busy_o} !== {ST_COUNT, 1'b0}) begin n_fail++; $display("FAIL cfg_nosample: got st=%0d busy=%0d want %0d/0", state_o, busy_o, ST_COUNT); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      @(negedge clk);
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL cfg_tick%0d: got busy=%0d want 0", i, busy_o); end
    end
    do_tick();
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL cfg_tick4: got busy=%0d want 1", busy_o); end
    step(4); @(negedge clk);
    n_chk++; if ({count_o, max_t_o, min_t_o} !== {4'd1, 8'd60, 8'd60}) begin n_fail++; $display("FAIL cfg_stats: got cnt=%0d max=%0d min=%0d want 1/60/60", count_o, max_t_o, min_t_o); end
    n_chk++; if (mem[0] !== 8'd60) begin n_fail++; $display("FAIL cfg_ram: got %0d want 60", mem[0]); end
  endtask

  task automatic test_en_drop();
    cfg_we_i = 1'b1; cfg_frq_i = 8'd0;
    step(1);
    cfg_we_i = 1'b0;
    temp_i = 8'd25;
    do_tick();                     // T
    en_i = 1'b0;
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL endrop_busy: got %0d want 1", busy_o); end
    step(2); @(negedge clk);       // T+3
    n_chk++; if ({buf_we_o, buf_waddr_o, buf_wdata_o} !== {1'b1, 3'd1, 8'd25}) begin n_fail++; $display("FAIL endrop_write: got we=%0d addr=%0d data=%0d want 1/1/25", buf_we_o, buf_waddr_o, buf_wdata_o); end
    step(2); @(negedge clk);       // T+5
    n_chk++; if ({state_o, count_o, min_t_o} !== {ST_IDLE, 4'd2, 8'd25}) begin n_fail++; $display("FAIL endrop_idle: got st=%0d cnt=%0d min=%0d want %0d/2/25", state_o, count_o, min_t_o, ST_IDLE); end
    do_tick();
    @(negedge clk);
    n_chk++; if ({state_o, busy_o} !== {ST_IDLE, 1'b0}) begin n_fail++; $display("FAIL endrop_tick: got st=%0d busy=%0d want %0d/0", state_o, busy_o, ST_IDLE); end
  endtask

  task automatic test_reset_mid();
    int we0;
    en_i = 1'b1;
    step(1);
    temp_i = 8'd33;
    we0 = we_cnt;
    do_tick();                     // T
    step(1);                       // T+2 READ_OLD
    reset_i = 1'b1;
    @(negedge clk);
    n_chk++; if (state_o !== ST_READ_OLD) begin n_fail++; $display("FAIL rmid_state: got %0d want %0d", state_o, ST_READ_OLD); end
    step(1); @(negedge clk);       // T+3
    n_chk++; if ({buf_we_o, state_o, count_o} !== {1'b0, ST_IDLE, 4'd0}) begin n_fail++; $display("FAIL rmid_abort: got we=%0d st=%0d cnt=%0d want 0/%0d/0", buf_we_o, state_o, count_o, ST_IDLE); end
    reset_i = 1'b0;
    step(2);
    n_chk++; if (we_cnt != we0) begin n_fail++; $display("FAIL rmid_writes: got %0d want %0d", we_cnt, we0); end
    n_chk++; if (mem[2] !== 8'd50) begin n_fail++; $display("FAIL rmid_ram: got %0d want 50", mem[2]); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_chk = 0; n_fail = 0; we_cnt = 0; ov_cnt = 0;
    reset_i = 1'b1; tick_i = 1'b0; temp_i = '0; en_i = 1'b0;
    clear_i = 1'b0; cfg_we_i = 1'b0; cfg_frq_i = '0;
    test_reset();
    test_single_sample();
    test_fill_ring();
    test_overwrite();
    test_overrun();
    test_clear();
    test_cfg_tick();
    test_en_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
